// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: datapath width, bubble encoding,
// default boot address and the fetch FSM state type.
package mips_pkg;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // BOOT: nothing in flight, RUN: one imem request in flight,
  // HOLD: stalled with the returned word parked in the skid register.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush has priority over load; pc+4 is computed on
// the way in so decode sees a registered value.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic                      flush_i,
  input  logic [mips_pkg::XLEN-1:0] instr_i,
  input  logic [mips_pkg::XLEN-1:0] pc_i,
  input  logic                      valid_i,
  output logic [mips_pkg::XLEN-1:0] instr_o,
  output logic [mips_pkg::XLEN-1:0] pc_o,
  output logic [mips_pkg::XLEN-1:0] pc4_o,
  output logic                      valid_o
);
  import mips_pkg::*;

  logic [XLEN-1:0] instr_q, pc_q, pc4_q;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      // Bubbles carry pc4=0 so they look identical to a reset/flushed entry.
      pc4_q   <= valid_i ? pc_i + 32'd4 : '0;
      valid_q <= valid_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: registered PC driving a 1-cycle imem, a one-entry
// skid buffer that parks the in-flight word across stalls, and redirect flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [mips_pkg::XLEN-1:0] redirect_pc,
  output logic [mips_pkg::XLEN-1:0] imem_addr,
  input  logic [mips_pkg::XLEN-1:0] imem_rdata,
  output logic [mips_pkg::XLEN-1:0] if_id_instr,
  output logic [mips_pkg::XLEN-1:0] if_id_pc,
  output logic [mips_pkg::XLEN-1:0] if_id_pc4,
  output logic                      if_id_valid
);
  import mips_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            req_valid, skid_valid;

  logic            ld, fl, ld_valid;
  logic [XLEN-1:0] ld_instr, ld_pc;

  // The FSM state fully encodes both flags: RUN <=> request in flight,
  // HOLD <=> skid occupied.
  assign req_valid  = (state_q == RUN);
  assign skid_valid = (state_q == HOLD);
  assign imem_addr  = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ld           = 1'b0;
    fl           = 1'b0;
    ld_instr     = NOP_INSTR;
    ld_pc        = '0;
    ld_valid     = 1'b0;

    if (redirect_valid) begin
      pc_d    = redirect_pc & ~32'h3;
      fl      = 1'b1;
      state_d = BOOT;
    end else if (stall) begin
      // Catch the returning word now; imem will not hold it for us.
      if (req_valid) begin
        skid_instr_d = imem_rdata;
        skid_pc_d    = req_pc_q;
      end
      state_d = (req_valid || skid_valid) ? HOLD : BOOT;
    end else begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
      state_d  = RUN;
      ld       = 1'b1;
      if (skid_valid) begin
        ld_instr = skid_instr_q;
        ld_pc    = skid_pc_q;
        ld_valid = 1'b1;
      end else if (req_valid) begin
        ld_instr = imem_rdata;
        ld_pc    = req_pc_q;
        ld_valid = 1'b1;
      end
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ld),
    .flush_i (fl),
    .instr_i (ld_instr),
    .pc_i    (ld_pc),
    .valid_i (ld_valid),
    .instr_o (if_id_instr),
    .pc_o    (if_id_pc),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; imem word at byte address a is a>>2.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;
  logic        if_id_valid;

  int n_chk = 0;
  int n_pass = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem_addr >> 2;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, 32'd1);
    chk({tag, ".pc"}, if_id_pc, pc);
    chk({tag, ".pc4"}, if_id_pc4, pc + 32'd4);
    chk({tag, ".instr"}, if_id_instr, instr);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst.valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst.instr", if_id_instr, 32'h0);
    chk("rst.pc", if_id_pc, 32'h0);
    chk("rst.pc4", if_id_pc4, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Streaming from reset
    tick(); chk_bubble("boot1"); chk("boot1.addr", imem_addr, 32'h4);
    tick(); chk_ifid("s0", 32'h0, 32'd0);
    tick(); chk_ifid("s1", 32'h4, 32'd1);
    tick(); chk_ifid("s2", 32'h8, 32'd2);
    tick(); chk_ifid("s3", 32'hC, 32'd3);

    // Stall three cycles with pc 8 in flight
    do_reset();
    tick(); tick(); tick();
    chk_ifid("pre_stall", 32'h4, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ifid("stall", 32'h4, 32'd1);
      chk("stall.addr", imem_addr, 32'hC);
    end
    stall = 1'b0;
    tick(); chk_ifid("rel0", 32'h8, 32'd2);
    tick(); chk_ifid("rel1", 32'hC, 32'd3);
    tick(); chk_ifid("rel2", 32'h10, 32'd4);

    // Redirect while streaming
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick(); chk_bubble("rd0"); chk("rd0.addr", imem_addr, 32'h40);
    chk("rd0.pc", if_id_pc, 32'h0);
    redirect_valid = 1'b0;
    tick(); chk_bubble("rd1");
    tick(); chk_ifid("rd2", 32'h40, 32'h10);
    tick(); chk_ifid("rd3", 32'h44, 32'h11);

    // Fill skid, then redirect+stall together (low pc bits forced to 0)
    stall = 1'b1;
    tick(); tick();
    chk_ifid("skid_hold", 32'h44, 32'h11);
    redirect_valid = 1'b1; redirect_pc = 32'h83;
    tick(); chk_bubble("rs0"); chk("rs0.addr", imem_addr, 32'h80);
    redirect_valid = 1'b0; stall = 1'b0;
    tick(); chk_bubble("rs1");
    tick(); chk_ifid("rs2", 32'h80, 32'h20);
    tick(); chk_ifid("rs3", 32'h84, 32'h21);

    // PC wrap at 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick(); chk_ifid("wrap0", 32'hFFFF_FFF8, 32'h3FFF_FFFE);
    tick(); chk_ifid("wrap1", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    tick(); chk_ifid("wrap2", 32'h0000_0000, 32'h0);

    // Async reset mid-stall with skid full
    stall = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, if_id_valid}, 32'd0);
    chk("arst.pc", if_id_pc, 32'h0);
    chk("arst.pc4", if_id_pc4, 32'h0);
    chk("arst.instr", if_id_instr, 32'h0);
    chk("arst.addr", imem_addr, 32'h0);
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); chk_bubble("arst_b");
    tick(); chk_ifid("arst0", 32'h0, 32'd0);
    tick(); chk_ifid("arst1", 32'h4, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0000, instruction word injected for bubbles.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 stall  input  1  hazard unit holds the fetch stage and the IF/ID register.
REQ-006 redirect_valid  input  1  taken branch/jump; discard wrong-path fetches.
REQ-007 redirect_pc  input  32  new fetch address; sampled only when redirect_valid=1.
REQ-008 imem_addr  output  32  byte address to instruction memory; sampled by the memory at posedge, data returned one cycle later.
REQ-009 imem_rdata  input  32  instruction for the address presented at the previous posedge.
REQ-010 if_id_instr  output  32  instruction for decode.
REQ-011 if_id_pc  output  32  address of if_id_instr.
REQ-012 if_id_pc4  output  32  if_id_pc + 4.
REQ-013 if_id_valid  output  1  1 = if_id_instr is a real instruction; 0 = bubble.

Function
REQ-014 imem_addr SHALL equal registered pc_q; no combinational path from any input to imem_addr.
REQ-015 FSM states SHALL be BOOT (nothing in flight), RUN (one request in flight), HOLD (stalled, response parked in a 1-entry skid register).
REQ-016 Advance cycle (stall=0, redirect_valid=0): pc_q <= pc_q+4, req_pc_q <= pc_q, req_valid_q <= 1; state -> RUN.
REQ-017 IF/ID load on advance: if skid_valid, load skid (instr, pc) and clear skid_valid; else if req_valid_q, load imem_rdata with req_pc_q, valid=1; else load NOP_INSTR, valid=0.
REQ-018 Stall cycle (stall=1, redirect_valid=0): pc_q, IF/ID and skid-full state SHALL hold; if req_valid_q=1 and skid empty, capture imem_rdata/req_pc_q into skid; req_valid_q <= 0; state -> HOLD if skid full, else BOOT.
REQ-019 Stall release from HOLD SHALL present the skid entry then the next sequential instruction on consecutive cycles: no bubble, no duplicate, no drop.
REQ-020 Redirect (redirect_valid=1) SHALL have priority over stall: pc_q <= redirect_pc, req_valid_q <= 0, skid_valid <= 0, IF/ID <= NOP_INSTR with valid=0 and pc=0; state -> BOOT.
REQ-021 After redirect the first valid IF/ID entry SHALL be redirect_pc exactly two cycles after the redirect edge.
REQ-022 pc arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-023 redirect_pc[1:0] SHALL be forced to 2'b00.
REQ-024 if_id_pc4 SHALL be registered alongside if_id_pc, not computed combinationally at the output.

Reset
REQ-025 On rst_n=0, immediately: pc_q=RESET_PC, req_valid_q=0, skid_valid=0, state=BOOT, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc4=0, if_id_valid=0.
REQ-026 First valid IF/ID entry (RESET_PC) SHALL appear on the second posedge after rst_n deasserts with stall=0.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight and parked data.

Structure
REQ-028 NOP_INSTR, RESET_PC default, XLEN=32 and the FSM state enum SHALL live in shared package mips_pkg.
REQ-029 IF/ID register (instr, pc, pc4, valid with load/flush) SHALL be sub-module if_id_reg; PC, skid and FSM stay in fetch_unit.

Verification
REQ-030 Reset release, stall=0, memory word k = k: if_id_pc = 0,4,8,12 on consecutive cycles from the second edge; if_id_instr = 0,1,2,3; valid=1.
REQ-031 Stall held 3 cycles while pc 8 in flight: IF/ID holds pc 4 throughout; after release pc 8 then pc 12 on consecutive cycles.
REQ-032 redirect_valid=1 with redirect_pc=0x40 while streaming: next cycle valid=0; two cycles after the redirect, if_id_pc=0x40; the wrong-path word never appears.
REQ-033 redirect_valid and stall both asserted, redirect_pc=0x80: redirect taken, skid cleared, if_id_pc=0x80 two cycles after release.
REQ-034 Start at pc 0xFFFF_FFF8: if_id_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-035 rst_n pulsed low mid-stall with skid full: outputs return to reset values without waiting for clk; the parked instruction is never delivered.
